// File: rtl/vga_pattern_gen_pkg.sv
// Shared pattern-generator definitions: mode codes, colour constants and the bar colour table.
package vga_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_BORDER = 2'd0,
    MODE_CHECK  = 2'd1,
    MODE_GRAD   = 2'd2,
    MODE_BARS   = 2'd3
  } mode_e;

  localparam logic [11:0] BLACK   = 12'h000;
  localparam logic [11:0] WHITE   = 12'hfff;
  localparam logic [11:0] YELLOW  = 12'hff0;
  localparam logic [11:0] CYAN    = 12'h0ff;
  localparam logic [11:0] GREEN   = 12'h0f0;
  localparam logic [11:0] MAGENTA = 12'hf0f;
  localparam logic [11:0] RED     = 12'hf00;
  localparam logic [11:0] BLUE    = 12'h00f;
  localparam logic [11:0] GRAY    = 12'h888;

  function automatic logic [11:0] bar_color(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = WHITE;
      3'd1:    c = YELLOW;
      3'd2:    c = CYAN;
      3'd3:    c = GREEN;
      3'd4:    c = MAGENTA;
      3'd5:    c = RED;
      3'd6:    c = BLUE;
      default: c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with async reset to zero; latency is DEPTH cycles.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_pattern_gen.sv
// Background test-pattern stage: border/checker/gradient/scrolling bars, config latched at frame start.
// Timing and colour leave PIPE_STAGES cycles after entry; frame_cnt is undelayed.
module vga_pattern_gen
  import vga_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 600,
  parameter int CNT_W       = 11,
  parameter int BORDER_W    = 1,
  parameter int CHECK_LOG2  = 5,
  parameter int BAR_LOG2    = 7,
  parameter int SCROLL_STEP = 2,
  parameter int PIPE_STAGES = 2
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [CNT_W-1:0] vcount_in,
  input  logic             vsync_in,
  input  logic             vblnk_in,
  input  logic [CNT_W-1:0] hcount_in,
  input  logic             hsync_in,
  input  logic             hblnk_in,
  input  logic [1:0]       mode_in,
  input  logic [11:0]      fill_in,
  input  logic             cfg_wr,
  output logic [CNT_W-1:0] vcount_out,
  output logic             vsync_out,
  output logic             vblnk_out,
  output logic [CNT_W-1:0] hcount_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic [11:0]      rgb_out,
  output logic [7:0]       frame_cnt
);

  localparam int SUM_W  = CNT_W + 1;
  localparam int TIM_W  = 2 * CNT_W + 4;

  localparam logic [CNT_W-1:0] H_MAX     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_MAX     = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] BW        = CNT_W'(BORDER_W);
  localparam logic [CNT_W-1:0] H_BORD_HI = CNT_W'(H_ACTIVE - BORDER_W);
  localparam logic [CNT_W-1:0] V_BORD_HI = CNT_W'(V_ACTIVE - BORDER_W);

  logic        vblnk_prev_q, vblnk_prev_d;
  mode_e       shadow_mode_q, shadow_mode_d;
  logic [11:0] shadow_fill_q, shadow_fill_d;
  mode_e       act_mode_q, act_mode_d;
  logic [11:0] act_fill_q, act_fill_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;

  logic             boundary;
  logic [SUM_W-1:0] bar_sum;
  logic [2:0]       bar_idx;
  logic [11:0]      pix_rgb;
  logic [TIM_W-1:0] timing_dly;

  // Active config is loaded from the shadow that existed before this edge, so a
  // cfg_wr coinciding with the boundary only lands one frame later.
  always_comb begin
    boundary      = vblnk_in & ~vblnk_prev_q;
    vblnk_prev_d  = vblnk_in;
    shadow_mode_d = shadow_mode_q;
    shadow_fill_d = shadow_fill_q;
    act_mode_d    = act_mode_q;
    act_fill_d    = act_fill_q;
    frame_cnt_d   = frame_cnt_q;
    if (cfg_wr) begin
      shadow_mode_d = mode_e'(mode_in);
      shadow_fill_d = fill_in;
    end
    if (boundary) begin
      act_mode_d  = shadow_mode_q;
      act_fill_d  = shadow_fill_q;
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vblnk_prev_q  <= 1'b0;
      shadow_mode_q <= MODE_BORDER;
      shadow_fill_q <= GRAY;
      act_mode_q    <= MODE_BORDER;
      act_fill_q    <= GRAY;
      frame_cnt_q   <= 8'd0;
    end else begin
      vblnk_prev_q  <= vblnk_prev_d;
      shadow_mode_q <= shadow_mode_d;
      shadow_fill_q <= shadow_fill_d;
      act_mode_q    <= act_mode_d;
      act_fill_q    <= act_fill_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  always_comb begin
    bar_sum = SUM_W'(hcount_in) + SUM_W'(frame_cnt_q) * SUM_W'(SCROLL_STEP);
    bar_idx = 3'(bar_sum >> BAR_LOG2);
    pix_rgb = BLACK;
    if (!(vblnk_in || hblnk_in) && (hcount_in < H_MAX) && (vcount_in < V_MAX)) begin
      case (act_mode_q)
        MODE_BORDER: begin
          if (vcount_in < BW)              pix_rgb = YELLOW;
          else if (vcount_in >= V_BORD_HI) pix_rgb = RED;
          else if (hcount_in < BW)         pix_rgb = GREEN;
          else if (hcount_in >= H_BORD_HI) pix_rgb = BLUE;
          else                             pix_rgb = act_fill_q;
        end
        MODE_CHECK:
          pix_rgb = (hcount_in[CHECK_LOG2] ^ vcount_in[CHECK_LOG2]) ? ~act_fill_q : act_fill_q;
        MODE_GRAD:
          pix_rgb = {hcount_in[9:6], vcount_in[9:6], act_fill_q[3:0]};
        MODE_BARS:
          pix_rgb = bar_color(bar_idx);
      endcase
    end
  end

  vga_delay_line #(.WIDTH(TIM_W), .DEPTH(PIPE_STAGES)) u_timing_dly (
    .pclk (pclk),
    .rst  (rst),
    .din  ({vcount_in, vsync_in, vblnk_in, hcount_in, hsync_in, hblnk_in}),
    .dout (timing_dly)
  );

  vga_delay_line #(.WIDTH(12), .DEPTH(PIPE_STAGES)) u_rgb_dly (
    .pclk (pclk),
    .rst  (rst),
    .din  (pix_rgb),
    .dout (rgb_out)
  );

  assign {vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out} = timing_dly;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench: four instances (PIPE_STAGES 1..4, BORDER_W=4) share one stimulus; index 1 is the main DUT.
module tb_vga_pattern_gen;

  logic        pclk;
  logic        rst;
  logic [10:0] vcount_in, hcount_in;
  logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
  logic [1:0]  mode_in;
  logic [11:0] fill_in;
  logic        cfg_wr;

  logic [10:0] vc_o  [4];
  logic [10:0] hc_o  [4];
  logic        vs_o  [4];
  logic        vb_o  [4];
  logic        hs_o  [4];
  logic        hb_o  [4];
  logic [11:0] rgb_o [4];
  logic [7:0]  fc_o  [4];

  int checks = 0;
  int errors = 0;
  int exp_fc = 0;
  int hist [12];
  logic [11:0] bar_tab [8] = '{12'hfff, 12'hff0, 12'h0ff, 12'h0f0,
                               12'hf0f, 12'hf00, 12'h00f, 12'h000};

  for (genvar g = 0; g < 4; g++) begin : g_dut
    vga_pattern_gen #(.BORDER_W(4), .PIPE_STAGES(g + 1)) u_dut (
      .pclk       (pclk),
      .rst        (rst),
      .vcount_in  (vcount_in),
      .vsync_in   (vsync_in),
      .vblnk_in   (vblnk_in),
      .hcount_in  (hcount_in),
      .hsync_in   (hsync_in),
      .hblnk_in   (hblnk_in),
      .mode_in    (mode_in),
      .fill_in    (fill_in),
      .cfg_wr     (cfg_wr),
      .vcount_out (vc_o[g]),
      .vsync_out  (vs_o[g]),
      .vblnk_out  (vb_o[g]),
      .hcount_out (hc_o[g]),
      .hsync_out  (hs_o[g]),
      .hblnk_out  (hb_o[g]),
      .rgb_out    (rgb_o[g]),
      .frame_cnt  (fc_o[g])
    );
  end

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int h, input int v, input logic hb, input logic vb);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    vblnk_in  = vb;
    hsync_in  = 1'b0;
    vsync_in  = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] m, input logic [11:0] f);
    mode_in = m;
    fill_in = f;
    cfg_wr  = 1'b1;
    tick(1);
    cfg_wr  = 1'b0;
  endtask

  task automatic pix(input string tag, input int h, input int v, input logic [11:0] exp);
    drive(h, v, 1'b0, 1'b0);
    tick(2);
    chk(tag, rgb_o[1], exp);
  endtask

  task automatic frame();
    drive(0, 600, 1'b1, 1'b1);
    tick(1);
    exp_fc = (exp_fc + 1) % 256;
    chk("fc_edge", fc_o[1], exp_fc);
    tick(1);
    chk("fc_once", fc_o[1], exp_fc);
    chk("vblank_black", rgb_o[1], 0);
    drive(0, 0, 1'b0, 1'b0);
    tick(1);
  endtask

  function automatic logic [11:0] bars(input int h, input int fc);
    return bar_tab[((h + fc * 2) >> 7) & 7];
  endfunction

  initial begin
    rst = 1'b1;
    mode_in = 2'd0;
    fill_in = 12'h000;
    cfg_wr = 1'b0;
    drive(0, 0, 1'b0, 1'b0);
    tick(2);
    chk("rst_rgb", rgb_o[1], 0);
    chk("rst_hcount", hc_o[1], 0);
    chk("rst_fc", fc_o[1], 0);

    // Release, exact latency into row 0, then interior default fill
    rst = 1'b0;
    drive(100, 0, 1'b0, 1'b0);
    tick(1);
    chk("lat_early", rgb_o[1], 0);
    tick(1);
    chk("row0", rgb_o[1], 12'hff0);
    pix("interior", 100, 300, 12'h888);
    chk("hcount_out", hc_o[1], 100);
    chk("vcount_out", vc_o[1], 300);

    // Mid-line reset blanks within the same cycle
    rst = 1'b1;
    #1;
    chk("midrst_rgb", rgb_o[1], 0);
    chk("midrst_hcount", hc_o[1], 0);
    chk("midrst_vcount", vc_o[1], 0);
    tick(1);
    rst = 1'b0;
    pix("resume", 100, 300, 12'h888);

    // Border mode, BORDER_W=4
    pix("b_h3", 3, 300, 12'h0f0);
    pix("b_h4", 4, 300, 12'h888);
    pix("b_h0v0", 0, 0, 12'hff0);
    pix("b_corner", 799, 599, 12'hf00);
    pix("b_v596", 100, 596, 12'hf00);
    pix("b_h796", 796, 300, 12'h00f);
    pix("b_h795", 795, 300, 12'h888);
    pix("blk_h800", 800, 300, 12'h000);
    pix("blk_v600", 100, 600, 12'h000);
    drive(100, 300, 1'b1, 1'b0);
    tick(2);
    chk("blk_hblnk", rgb_o[1], 0);

    drive(100, 300, 1'b0, 1'b0);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    tick(1);
    chk("hsync_early", hs_o[1], 0);
    tick(1);
    chk("hsync_out", hs_o[1], 1);
    chk("vsync_out", vs_o[1], 1);

    // Mid-frame config waits for the next frame
    drive(100, 300, 1'b0, 1'b0);
    cfg(2'd1, 12'h123);
    pix("cfg_hold_fill", 100, 300, 12'h888);
    pix("cfg_hold_mode", 3, 300, 12'h0f0);
    frame();
    pix("chk_0_0", 0, 0, 12'h123);
    pix("chk_32_0", 32, 0, 12'hedc);
    pix("chk_32_32", 32, 32, 12'h123);

    // Config on the boundary cycle itself
    drive(0, 600, 1'b1, 1'b1);
    mode_in = 2'd2;
    fill_in = 12'h00a;
    cfg_wr = 1'b1;
    tick(1);
    cfg_wr = 1'b0;
    exp_fc = (exp_fc + 1) % 256;
    chk("fc_bnd_cfg", fc_o[1], exp_fc);
    tick(1);
    chk("fc_bnd_once", fc_o[1], exp_fc);
    drive(0, 0, 1'b0, 1'b0);
    tick(1);
    pix("bnd_old_mode", 32, 0, 12'hedc);
    frame();
    pix("grad", 448, 200, 12'h73a);

    // Scrolling bars over a full frame-counter wrap
    cfg(2'd3, 12'h000);
    frame();
    pix("bars_first", 0, 100, bars(0, exp_fc));
    for (int f = 0; f < 256; f++) begin
      frame();
      if ((exp_fc % 64) == 63 || (exp_fc % 64) == 0) begin
        pix("bars_h0", 0, 100, bars(0, exp_fc));
      end
      if (exp_fc == 0) begin
        pix("bars_wrap_h0", 0, 100, 12'hfff);
        pix("bars_wrap_h128", 128, 100, 12'hff0);
        pix("bars_wrap_h768", 768, 100, 12'h00f);
        pix("bars_blk_h800", 800, 100, 12'h000);
      end
      if (exp_fc == 64) begin
        pix("bars_64_h0", 0, 100, 12'hff0);
      end
    end

    // Latency alignment for every depth, cycle by cycle
    for (int i = 0; i < 12; i++) begin
      drive(240 + i, 100, 1'b0, 1'b0);
      hist[i] = 240 + i;
      tick(1);
      for (int n = 1; n <= 4; n++) begin
        if (i >= n - 1) begin
          chk("align_hcount", hc_o[n-1], hist[i-n+1]);
          chk("align_rgb", rgb_o[n-1], bars(hist[i-n+1], exp_fc));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
